// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start bit, DATA_W payload bits LSB first, optional parity, one or two stop bits.
// Parity support is compiled in only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_frame_gen #(
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] P_DATA,
   input  logic              data_valid,
   input  logic              par_en,
   input  logic              par_typ,
   input  logic              stop2,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP1  = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [DATA_W-1:0] data_lat;
   logic              stop2_lat;
   logic              final_stop;
   logic              accept;
   logic              tx_nxt;
   logic              done_nxt;

`ifdef UART_TX_PARITY_EN
   logic              par_en_lat;
   logic              par_typ_lat;

   // Even parity is the XOR of the payload; odd parity is its inverse.
   function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction
`else
   logic              unused_par_cfg;
   assign unused_par_cfg = par_en ^ par_typ;
`endif

   // A new request is taken only when idle or in the last stop-bit cycle.
   always_comb begin
      final_stop = (state == ST_STOP2) || ((state == ST_STOP1) && !stop2_lat);
      accept     = data_valid && ((state == ST_IDLE) || final_stop);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_START;
         end
         ST_START: begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
         end
         ST_DATA: begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = par_en_lat ? ST_PARITY : ST_STOP1;
`else
               state_nxt = ST_STOP1;
`endif
            end else begin
               cnt_nxt = bit_cnt + CNT_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            state_nxt = ST_STOP1;
         end
`endif
         ST_STOP1: begin
            if (stop2_lat)   state_nxt = ST_STOP2;
            else if (accept) state_nxt = ST_START;
            else             state_nxt = ST_IDLE;
         end
         ST_STOP2: begin
            state_nxt = accept ? ST_START : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are computed from the next state so the registers present the
   // line level of the state being entered, with no decode glitch.
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         ST_START:  tx_nxt = 1'b0;
         ST_DATA:   tx_nxt = data_lat[cnt_nxt];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_nxt = parity_bit(data_lat, par_typ_lat);
`endif
         default:   tx_nxt = 1'b1;
      endcase
      done_nxt = (state_nxt == ST_STOP2) || ((state_nxt == ST_STOP1) && !stop2_lat);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         data_lat    <= '0;
         stop2_lat   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_lat  <= 1'b0;
         par_typ_lat <= 1'b0;
`endif
         tx_out      <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= cnt_nxt;
         if (accept) begin
            data_lat    <= P_DATA;
            stop2_lat   <= stop2;
`ifdef UART_TX_PARITY_EN
            par_en_lat  <= par_en;
            par_typ_lat <= par_typ;
`endif
         end
         tx_out <= tx_nxt;
         busy   <= (state_nxt != ST_IDLE);
         done   <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: table of whole frames plus hand-written
// sequences for back-to-back, ignored requests and reset handling.
module tb_uart_tx_frame_gen;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       stop2;
   logic       tx_out;
   logic       busy;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_frame_gen #(.DATA_W(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .stop2      (stop2),
      .tx_out     (tx_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 CLK = ~CLK;

   // bits holds the expected line levels, first cycle in bit [len-1].
   typedef struct {
      logic [7:0]  data;
      logic        pe;
      logic        pt;
      logic        s2;
      logic [15:0] bits;
      int          len;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string what, input int tag, input int cyc,
                        input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s seq%0d cyc%0d: got %b, expected %b", what, tag, cyc, act, exp);
      end
   endtask

   task automatic cycle_check(input int tag, input int cyc, input logic e_tx,
                              input logic e_busy, input logic e_done);
      @(negedge CLK);
      check("tx_out", tag, cyc, tx_out, e_tx);
      check("busy",   tag, cyc, busy,   e_busy);
      check("done",   tag, cyc, done,   e_done);
   endtask

   task automatic start(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
      @(negedge CLK);
      P_DATA     = d;
      par_en     = pe;
      par_typ    = pt;
      stop2      = s2;
      data_valid = 1'b1;
   endtask

   // Inputs are inverted right after acceptance to show the frame uses latched copies.
   task automatic run_frame(input vec_t v, input int tag);
      start(v.data, v.pe, v.pt, v.s2);
      for (int i = 0; i < v.len; i++) begin
         cycle_check(tag, i, v.bits[v.len-1-i], 1'b1, i == v.len - 1);
         if (i == 0) begin
            data_valid = 1'b0;
            P_DATA     = ~v.data;
            par_en     = ~v.pe;
            par_typ    = ~v.pt;
            stop2      = ~v.s2;
         end
      end
      cycle_check(tag, v.len, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [15:0] b;
      RST = 1'b1; P_DATA = 8'h00; data_valid = 1'b0;
      par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;

`ifdef UART_TX_PARITY_EN
      tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 16'(11'b0_10100101_0_1),   11};
      tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 16'(11'b0_10100101_1_1),   11};
      tbl[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 16'(12'b0_10100101_0_1_1), 12};
      tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 16'(10'b0_00111100_1),     10};
      tbl[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 16'(12'b0_10000000_1_1_1), 12};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 16'(11'b0_11111111_1_1),   11};
      tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 16'(12'b0_00000000_1_1_1), 12};
`else
      tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 16'(10'b0_10100101_1),     10};
      tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 16'(10'b0_10100101_1),     10};
      tbl[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 16'(11'b0_10100101_1_1),   11};
      tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 16'(10'b0_00111100_1),     10};
      tbl[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 16'(11'b0_10000000_1_1),   11};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 16'(10'b0_11111111_1),     10};
      tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 16'(11'b0_00000000_1_1),   11};
`endif

      // Reset state
      @(negedge CLK);
      cycle_check(100, 0, 1'b1, 1'b0, 1'b0);
      RST = 1'b0;
      cycle_check(100, 1, 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < 7; k++) run_frame(tbl[k], k);

      // Back-to-back: 0x3C requested in the final stop cycle of the 0xA5 frame
      start(tbl[0].data, tbl[0].pe, tbl[0].pt, tbl[0].s2);
      for (int i = 0; i < tbl[0].len; i++) begin
         cycle_check(200, i, tbl[0].bits[tbl[0].len-1-i], 1'b1, i == tbl[0].len - 1);
         if (i == 0) data_valid = 1'b0;
         if (i == tbl[0].len - 1) begin
            P_DATA = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
            data_valid = 1'b1;
         end
      end
      b = 16'(10'b0_00111100_1);
      for (int i = 0; i < 10; i++) begin
         cycle_check(201, i, b[9-i], 1'b1, i == 9);
         if (i == 0) data_valid = 1'b0;
      end
      cycle_check(201, 10, 1'b1, 1'b0, 1'b0);

      // Request during DATA bit 3 is dropped, not queued
      b = 16'(10'b0_10100101_1);
      start(8'hA5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle_check(300, i, b[9-i], 1'b1, i == 9);
         if (i == 0) data_valid = 1'b0;
         if (i == 4) begin P_DATA = 8'h3C; data_valid = 1'b1; end
         if (i == 5) data_valid = 1'b0;
      end
      for (int i = 10; i < 14; i++) cycle_check(300, i, 1'b1, 1'b0, 1'b0);

      // Reset during DATA bit 4 aborts the frame
      start(8'hA5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle_check(400, i, b[9-i], 1'b1, 1'b0);
         if (i == 0) data_valid = 1'b0;
      end
      RST = 1'b1;
      cycle_check(400, 6, 1'b1, 1'b0, 1'b0);
      RST = 1'b0;
      cycle_check(400, 7, 1'b1, 1'b0, 1'b0);
      run_frame(tbl[3], 401);

      // Reset wins over a simultaneous request
      start(8'hA5, 1'b0, 1'b0, 1'b0);
      RST = 1'b1;
      cycle_check(500, 0, 1'b1, 1'b0, 1'b0);
      RST = 1'b0;
      data_valid = 1'b0;
      cycle_check(500, 1, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
